// File: rtl/rmt_match_filter.sv
// Ingress match-action filter: parses the first beat of each packet (802.1Q + IPv4 + UDP).
// Control packets program a 16-entry {VID, UDP dport} table; data packets are forwarded or dropped.
module rmt_match_filter #(
  parameter int unsigned C_S_AXI_DATA_WIDTH   = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH   = 12,
  parameter logic [31:0] C_BASEADDR           = 32'h80000000,
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 512,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 512,
  parameter int unsigned PHV_ADDR_WIDTH       = 4
) (
  input  logic                               clk,
  input  logic                               aresetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
  input  logic                               s_axis_tvalid,
  output logic                               s_axis_tready,
  input  logic                               s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]   m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic                               m_axis_tlast
);

  localparam int Depth = 1 << PHV_ADDR_WIDTH;

  // Reserved AXI-Lite parameters are only sanity-checked; the parser needs bytes 0..52.
  if (C_M_AXIS_DATA_WIDTH != C_S_AXIS_DATA_WIDTH || C_S_AXIS_DATA_WIDTH < 424 ||
      C_S_AXI_DATA_WIDTH == 0 || C_S_AXI_ADDR_WIDTH == 0 || C_BASEADDR[1:0] != 2'b00 ||
      PHV_ADDR_WIDTH == 0 || PHV_ADDR_WIDTH > 4) begin : g_bad_cfg
    $error("rmt_match_filter: unsupported parameter set");
  end

  typedef enum logic {StFirst, StBody} state_e;

  state_e state_q, state_d;
  logic   fwd_q, fwd_d;

  logic [C_M_AXIS_DATA_WIDTH-1:0]   m_data_q;
  logic [C_M_AXIS_DATA_WIDTH/8-1:0] m_keep_q;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]  m_user_q;
  logic                             m_valid_q;
  logic                             m_last_q;

  logic [Depth-1:0] ent_valid_q;
  logic [Depth-1:0] ent_drop_q;
  logic [11:0]      ent_vid_q  [Depth];
  logic [15:0]      ent_port_q [Depth];

  // Header fields, big-endian: byte n lives at tdata[8n +: 8].
  logic [15:0] tpid, etype, dport;
  logic [11:0] vid;
  logic [7:0]  proto;
  logic [PHV_ADDR_WIDTH-1:0] ctl_idx;
  logic        ctl_valid, ctl_drop;
  logic [11:0] ctl_vid;
  logic [15:0] ctl_port;

  assign tpid      = {s_axis_tdata[96 +: 8], s_axis_tdata[104 +: 8]};
  assign vid       = {s_axis_tdata[112 +: 4], s_axis_tdata[120 +: 8]};
  assign etype     = {s_axis_tdata[128 +: 8], s_axis_tdata[136 +: 8]};
  assign proto     = s_axis_tdata[216 +: 8];
  assign dport     = {s_axis_tdata[320 +: 8], s_axis_tdata[328 +: 8]};
  assign ctl_idx   = s_axis_tdata[368 +: PHV_ADDR_WIDTH];
  assign ctl_valid = s_axis_tdata[376];
  assign ctl_vid   = {s_axis_tdata[384 +: 4], s_axis_tdata[392 +: 8]};
  assign ctl_port  = {s_axis_tdata[400 +: 8], s_axis_tdata[408 +: 8]};
  assign ctl_drop  = s_axis_tdata[416];

  logic s_hs, is_wf, is_ctrl, hit, hit_drop, first_fwd, beat_fwd, tbl_we;

  assign s_axis_tready = !m_valid_q || m_axis_tready;
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign is_wf         = (tpid == 16'h8100) && (etype == 16'h0800) && (proto == 8'h11);
  assign is_ctrl       = is_wf && (dport == 16'hF1F2);
  assign tbl_we        = s_hs && (state_q == StFirst) && is_ctrl;

  // Descending scan so the lowest matching index is the last one assigned.
  always_comb begin
    hit      = 1'b0;
    hit_drop = 1'b0;
    for (int i = Depth - 1; i >= 0; i--) begin
      if (ent_valid_q[i] && ent_vid_q[i] == vid && ent_port_q[i] == dport) begin
        hit      = 1'b1;
        hit_drop = ent_drop_q[i];
      end
    end
  end

  assign first_fwd = is_wf && !is_ctrl && hit && !hit_drop;

  always_comb begin
    state_d  = state_q;
    fwd_d    = fwd_q;
    beat_fwd = (state_q == StFirst) ? first_fwd : fwd_q;
    if (s_hs) begin
      unique case (state_q)
        StFirst: begin
          fwd_d = first_fwd;
          if (!s_axis_tlast) state_d = StBody;
        end
        StBody: begin
          if (s_axis_tlast) state_d = StFirst;
        end
        default: state_d = StFirst;
      endcase
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= StFirst;
      fwd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fwd_q   <= fwd_d;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      ent_valid_q <= '0;
      ent_drop_q  <= '0;
      for (int i = 0; i < Depth; i++) begin
        ent_vid_q[i]  <= '0;
        ent_port_q[i] <= '0;
      end
    end else if (tbl_we) begin
      ent_valid_q[ctl_idx] <= ctl_valid;
      ent_drop_q[ctl_idx]  <= ctl_drop;
      ent_vid_q[ctl_idx]   <= ctl_vid;
      ent_port_q[ctl_idx]  <= ctl_port;
    end
  end

  // Dropped beats still consume a slot in the handshake but leave the output empty.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_user_q  <= '0;
      m_last_q  <= 1'b0;
    end else if (s_hs) begin
      m_valid_q <= beat_fwd;
      if (beat_fwd) begin
        m_data_q <= s_axis_tdata;
        m_keep_q <= s_axis_tkeep;
        m_user_q <= s_axis_tuser;
        m_last_q <= s_axis_tlast;
      end
    end else if (m_axis_tready) begin
      m_valid_q <= 1'b0;
    end
  end

  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tuser  = m_user_q;
  assign m_axis_tlast  = m_last_q;

endmodule

// File: tb/tb_rmt_match_filter.sv
// Scoreboard bench for rmt_match_filter: driver pushes expected forwarded beats,
// a negedge monitor pops and compares every m_axis transfer.
module tb_rmt_match_filter;

  logic         clk = 1'b0;
  logic         aresetn;
  logic [511:0] s_axis_tdata;
  logic [63:0]  s_axis_tkeep;
  logic [127:0] s_axis_tuser;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [511:0] m_axis_tdata;
  logic [63:0]  m_axis_tkeep;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;

  always #5 clk = ~clk;

  rmt_match_filter dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  typedef struct packed {
    logic [511:0] d;
    logic [63:0]  k;
    logic [127:0] u;
    logic         l;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  int    out_count = 0;
  int    valid_seen = 0;
  logic  prev_stall = 1'b0;
  beat_t prev_beat;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: a transfer happens at the posedge following a negedge with valid && ready.
  always @(negedge clk) begin
    beat_t cur, e;
    cur = '{d: m_axis_tdata, k: m_axis_tkeep, u: m_axis_tuser, l: m_axis_tlast};
    if (!aresetn) begin
      prev_stall = 1'b0;
    end else begin
      if (m_axis_tvalid) valid_seen++;
      if (m_axis_tvalid && !m_axis_tready) check("tready_low_when_full", 512'(s_axis_tready), 0);
      if (prev_stall) begin
        check("stall_valid_held", 512'(m_axis_tvalid), 1);
        check("stall_data_held", cur.d, prev_beat.d);
        check("stall_side_held", 512'({cur.k, cur.u, cur.l}),
              512'({prev_beat.k, prev_beat.u, prev_beat.l}));
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_beat  = cur;
      if (m_axis_tvalid && m_axis_tready) begin
        out_count++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_beat: got tdata %0h required no output", cur.d);
        end else begin
          e = exp_q.pop_front();
          check("out_tdata", cur.d, e.d);
          check("out_tkeep", 512'(cur.k), 512'(e.k));
          check("out_tuser", 512'(cur.u), 512'(e.u));
          check("out_tlast", 512'(cur.l), 512'(e.l));
        end
      end
    end
  end

  function automatic logic [511:0] hdr(input logic [15:0] tpid, input logic [11:0] vid,
                                       input logic [15:0] etype, input logic [7:0] proto,
                                       input logic [15:0] dport, input logic [31:0] fill);
    logic [511:0] d;
    d = {16{fill}};
    d[96 +: 8]  = tpid[15:8];
    d[104 +: 8] = tpid[7:0];
    d[112 +: 8] = {4'hA, vid[11:8]};  // nonzero PCP/DEI bits must be ignored
    d[120 +: 8] = vid[7:0];
    d[128 +: 8] = etype[15:8];
    d[136 +: 8] = etype[7:0];
    d[216 +: 8] = proto;
    d[320 +: 8] = dport[15:8];
    d[328 +: 8] = dport[7:0];
    return d;
  endfunction

  task automatic send_beat(input logic [511:0] d, input logic [63:0] k, input logic [127:0] u,
                           input logic l, input logic fwd);
    logic acc;
    acc = 1'b0;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      if (s_axis_tready) acc = 1'b1;
      @(posedge clk);
    end
    if (!acc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: got no handshake required handshake within 200 cycles");
    end else if (fwd) begin
      exp_q.push_back('{d: d, k: k, u: u, l: l});
    end
    #1 s_axis_tvalid = 1'b0;
  endtask

  task automatic send_ctrl(input logic [3:0] idx, input logic vld, input logic [11:0] vid,
                           input logic [15:0] port, input logic drop);
    logic [511:0] d;
    d = hdr(16'h8100, 12'h123, 16'h0800, 8'h11, 16'hF1F2, 32'hC0C00000 | 32'(idx));
    d[368 +: 8] = {4'h5, idx};
    d[376 +: 8] = {7'h2A, vld};
    d[384 +: 8] = {4'h0, vid[11:8]};
    d[392 +: 8] = vid[7:0];
    d[400 +: 8] = port[15:8];
    d[408 +: 8] = port[7:0];
    d[416 +: 8] = {7'h00, drop};
    send_beat(d, 64'hFFFF_FFFF_FFFF_FFFF, 128'hC7, 1'b1, 1'b0);
  endtask

  // Multi-beat packet: header on the first beat, distinct fill on the rest.
  task automatic send_pkt(input logic [15:0] tpid, input logic [11:0] vid, input logic [15:0] et,
                          input logic [7:0] proto, input logic [15:0] port, input int nbeats,
                          input logic fwd, input logic [31:0] tag);
    logic [511:0] d;
    for (int b = 0; b < nbeats; b++) begin
      if (b == 0) d = hdr(tpid, vid, et, proto, port, tag);
      else        d = {16{tag ^ 32'(b * 32'h0101_0101)}};
      send_beat(d, (b == nbeats - 1) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF,
                {96'h0, tag + 32'(b)}, (b == nbeats - 1), fwd);
    end
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion required completion within 1 ms");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    aresetn       = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tuser  = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 512'(m_axis_tvalid), 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_tkeep_tuser_tlast", 512'({m_axis_tkeep, m_axis_tuser, m_axis_tlast}), 0);
    check("rst_tready", 512'(s_axis_tready), 1);
    aresetn = 1'b1;
    @(posedge clk);
    #1;

    // Drop after config: entries 0-3 never match port 0x10E1.
    base = out_count;
    for (int i = 0; i < 4; i++) send_ctrl(4'(i), 1'b1, 12'h00F, 16'h2000 + 16'(i), 1'b0);
    send_pkt(16'h8100, 12'h001, 16'h0800, 8'h11, 16'h10E1, 1, 1'b0, 32'h1111_0000);
    valid_seen = 0;
    repeat (1000) @(posedge clk);
    #1;
    check("idle_1000_valid_cycles", 512'(valid_seen), 0);
    check("cfg_miss_out_count", 512'(out_count - base), 0);

    // Forward hit with 1-cycle latency, checked right after each acceptance edge.
    send_ctrl(4'd2, 1'b1, 12'h001, 16'h10E1, 1'b0);
    base = out_count;
    send_pkt(16'h8100, 12'h001, 16'h0800, 8'h11, 16'h10E1, 1, 1'b1, 32'h2222_0000);
    check("lat_first_valid", 512'(m_axis_tvalid), 1);
    check("lat_first_data", m_axis_tdata,
          hdr(16'h8100, 12'h001, 16'h0800, 8'h11, 16'h10E1, 32'h2222_0000));
    settle();
    send_pkt(16'h8100, 12'h001, 16'h0800, 8'h11, 16'h10E1, 2, 1'b1, 32'h3333_0000);
    check("lat_last_valid", 512'({m_axis_tvalid, m_axis_tlast}), 3);
    settle();
    check("fwd_out_count", 512'(out_count - base), 3);

    // Priority: lowest index wins; invalidating entry 0 lets entry 7 forward.
    send_ctrl(4'd0, 1'b1, 12'h005, 16'd80, 1'b1);
    send_ctrl(4'd7, 1'b1, 12'h005, 16'd80, 1'b0);
    base = out_count;
    send_pkt(16'h8100, 12'h005, 16'h0800, 8'h11, 16'd80, 2, 1'b0, 32'h4444_0000);
    settle();
    check("prio_drop_count", 512'(out_count - base), 0);
    send_ctrl(4'd0, 1'b0, 12'h005, 16'd80, 1'b1);
    send_pkt(16'h8100, 12'h005, 16'h0800, 8'h11, 16'd80, 2, 1'b1, 32'h5555_0000);
    settle();
    check("prio_fwd_count", 512'(out_count - base), 2);

    // Malformed: untagged and TCP, both matching entry 2 by field position.
    base = out_count;
    send_pkt(16'h0800, 12'h001, 16'h0800, 8'h11, 16'h10E1, 2, 1'b0, 32'h6666_0000);
    send_pkt(16'h8100, 12'h001, 16'h0800, 8'h06, 16'h10E1, 1, 1'b0, 32'h7777_0000);
    settle();
    check("malformed_count", 512'(out_count - base), 0);

    // Backpressure: 5-cycle stall during a forwarded 3-beat packet.
    base = out_count;
    fork
      send_pkt(16'h8100, 12'h001, 16'h0800, 8'h11, 16'h10E1, 3, 1'b1, 32'h8888_0000);
      begin
        @(posedge clk);
        #1 m_axis_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("bp_tready_low", 512'({m_axis_tvalid, s_axis_tready}), 2);
        repeat (2) @(posedge clk);
        #1 m_axis_tready = 1'b1;
      end
    join
    settle();
    check("bp_out_count", 512'(out_count - base), 3);

    // Async reset between beat 1 and beat 2 of a forwarded packet.
    base = out_count;
    send_beat(hdr(16'h8100, 12'h001, 16'h0800, 8'h11, 16'h10E1, 32'h9999_0000),
              64'hFFFF_FFFF_FFFF_FFFF, 128'h99, 1'b0, 1'b1);
    aresetn = 1'b0;
    exp_q.delete();
    #1;
    check("rst_mid_tvalid", 512'(m_axis_tvalid), 0);
    check("rst_mid_tdata", m_axis_tdata, 0);
    repeat (2) @(posedge clk);
    #1 aresetn = 1'b1;
    @(posedge clk);
    #1;
    send_pkt(16'h8100, 12'h001, 16'h0800, 8'h11, 16'h10E1, 1, 1'b0, 32'hAAAA_0000);
    settle();
    check("rst_table_cleared", 512'(out_count - base), 0);
    send_ctrl(4'd2, 1'b1, 12'h001, 16'h10E1, 1'b0);
    send_pkt(16'h8100, 12'h001, 16'h0800, 8'h11, 16'h10E1, 2, 1'b1, 32'hBBBB_0000);
    settle();
    check("rst_reprogram_fwd", 512'(out_count - base), 2);
    check("scoreboard_drained", 512'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rmt_match_filter.md
# rmt_match_filter

Ingress match-action packet filter on a 512-bit AXI-Stream datapath, sitting between the MAC-side receive stream and the downstream packet pipeline. It parses the first beat of each packet (Ethernet + 802.1Q + IPv4 + UDP) and handles two packet kinds:
- Control packets program a 16-entry match table.
- Data packets are looked up in the table and either forwarded unchanged or dropped whole; a table miss drops the packet.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32, reserved AXI-Lite width (unused)
- C_S_AXI_ADDR_WIDTH, 12, reserved (unused)
- C_BASEADDR, 32'h80000000, reserved (unused)
- C_S_AXIS_DATA_WIDTH, 512, input stream data width
- C_S_AXIS_TUSER_WIDTH, 128, tuser width, both streams
- C_M_AXIS_DATA_WIDTH, 512, output stream data width (equals input)
- PHV_ADDR_WIDTH, 4, log2 of table depth (16 entries)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- aresetn  in  1  async active-low reset
- s_axis_tdata  in  512  packet data, byte 0 = bits[7:0] = first wire byte
- s_axis_tkeep  in  64  byte enables
- s_axis_tuser  in  128  sideband, passed through
- s_axis_tvalid  in  1
- s_axis_tready  out  1
- s_axis_tlast  in  1
- m_axis_tdata  out  512
- m_axis_tkeep  out  64
- m_axis_tuser  out  128
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tlast  out  1

## Operation
- **Header fields.** All are taken from the first beat of each packet. Multi-byte fields are big-endian (network order); the lower byte index is the MSB.
  - TPID = bytes 12-13.
  - VID = bytes 14-15 [11:0].
  - EtherType = bytes 16-17.
  - IP protocol = byte 27.
  - UDP dst port = bytes 40-41.
  - UDP payload starts at byte 46.
  - Fields are parsed regardless of tkeep.
- **Well-formed packet:** TPID = 0x8100, EtherType = 0x0800 and protocol = 0x11. Any other packet is dropped.
- **Control packet:** well-formed with UDP dst port 0xF1F2.
  - Control packets are always consumed and never forwarded.
  - Payload layout:
    - byte 46 [3:0] = entry index;
    - byte 47 bit0 = entry valid;
    - bytes 48-49 [11:0] = key VID;
    - bytes 50-51 = key UDP dst port;
    - byte 52 bit0 = action (0 = forward, 1 = drop).
  - The write occurs on the handshake of the control packet's first beat.
- **Data packet:** any other well-formed packet.
  - The lookup key is {VID, UDP dst port}, compared against all valid entries in parallel.
  - The lowest-index hit wins.
  - Hit with action 0: forward. Hit with action 1: drop. Miss: drop.
- **Per-packet decision.** The forward/drop decision is latched at the first-beat handshake and applied to every beat through tlast.
  - Dropped beats are accepted (handshaken) but never presented on m_axis.
- **Forwarded beats.** tdata, tkeep, tuser and tlast are passed unmodified.
- **Reset.**
  - All 16 table entries become invalid.
  - m_axis_tvalid = 0; m_axis_tdata, tkeep, tuser and tlast = 0.
  - The parser returns to the expecting-first-beat state.

## Timing
- **Output register.** There is one output register stage.
  - A forwarded beat accepted at edge N appears on m_axis from edge N (visible after edge N) and is held until the m_axis handshake.
  - Latency is 1 cycle.
- **Ready:** s_axis_tready = !m_axis_tvalid || m_axis_tready (combinational). Beats of dropped packets still obey this ready.
- **Throughput:** full rate, one beat per cycle, with continuous m_axis_tready.
- **Parser states:**
  - FIRST → BODY on a first-beat handshake with !tlast.
  - BODY → FIRST on the tlast handshake.
  - A single-beat packet stays in FIRST.
- **Table-write visibility.** A table write at edge N is visible to a data packet whose first beat is handshaken at edge N+1 or later.
  - A first beat handshaken in the same cycle as a write cannot occur, because only one beat is accepted per cycle.
- **Backpressure.** While m_axis_tvalid && !m_axis_tready, all m_axis outputs are stable and s_axis_tready = 0.
- **Reset mid-packet.** The partial packet is discarded, and the next handshaken beat is treated as a first beat.

## Test plan
- **Drop after config:**
  - Stimulus: reset; four control packets writing entries 0-3 with VID 0x00F and non-matching ports; then a single-beat data packet with VID 1, dst port 0x10E1.
  - Required: m_axis_tvalid stays 0 for 1000 cycles; control packets are never output.
- **Forward hit:**
  - Stimulus: write entry 2 = {valid, VID 1, port 0x10E1, action 0}; send a 2-beat packet with VID 1, port 0x10E1.
  - Required: both beats appear 1 cycle after acceptance with identical tdata, tkeep, tuser and tlast.
- **Priority:**
  - Stimulus: entry 0 = {VID 5, port 80, drop}, entry 7 = {VID 5, port 80, forward}; send a VID 5, port 80 packet.
  - Required: the packet is dropped. After invalidating entry 0, the same packet is forwarded.
- **Malformed:**
  - Stimulus: an untagged IPv4/UDP packet, and a VLAN-tagged TCP packet, both matching a forward entry by field position.
  - Required: both dropped.
- **Backpressure:**
  - Stimulus: hold m_axis_tready = 0 for 5 cycles during a forwarded 3-beat packet.
  - Required: s_axis_tready = 0 while output is full; no beat lost or duplicated; order preserved.
- **Async reset mid-packet:**
  - Stimulus: assert aresetn low between beat 1 and beat 2 of a forwarded packet.
  - Required: m_axis_tvalid = 0 immediately; table cleared; the next forward-key packet is dropped (miss).
